// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control FSM: states, opcodes, ALU and operand-mux selects.
// Pure definitions, so there is no latency and no backpressure.
package mc_pkg;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ASEL_PC    = 2'b00;
    localparam logic [1:0] ASEL_RS1   = 2'b01;
    localparam logic [1:0] ASEL_OLDPC = 2'b10;

    localparam logic [1:0] BSEL_RS2  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR = 2'b10;

    function automatic logic op_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_SD, OP_BEQ};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts consecutive memory wait cycles; expired is raised on the MAX_WAIT-th wait cycle.
// Expiry is combinational in that cycle; MAX_WAIT=0 builds no counter and never expires.
module mc_wait_timer #(
    parameter int MAX_WAIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clr,
    output logic expired
);

    generate
        if (MAX_WAIT == 0) begin : g_off
            logic unused_in;
            assign unused_in = &{1'b0, clk, rst_n, waiting, clr};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
            logic [W-1:0] cnt;

            // cnt holds the number of earlier wait cycles, so the current one is cnt+1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       cnt <= '0;
                else if (clr)     cnt <= '0;
                else if (waiting) cnt <= cnt + W'(1);
            end

            assign expired = waiting && (cnt == W'(MAX_WAIT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 control FSM; PERF_CNT_EN adds cycle/instret counters. Zero-wait latency: BEQ 3, R/I/SD 4, LD 5.
// Stalls in FETCH/MEM until mem_ready; with MAX_WAIT>0, an overlong stall traps with the timeout flag set.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 0,
    parameter int CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             aluout_we,
    output logic             mdr_we,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state, state_nxt;
    logic   waiting, expired, retire, illegal_set, timeout_set;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign state_o = state;

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clr     (state_nxt != state),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        retire      = 1'b0;
        case (state)
            S_BOOT:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_nxt = S_DECODE;
                else if (expired) begin
                    state_nxt   = S_TRAP;
                    timeout_set = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_legal(opcode)) state_nxt = S_EXEC;
                else begin
                    state_nxt   = S_TRAP;
                    illegal_set = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_I:   state_nxt = S_WB;
                    OP_LD, OP_SD: state_nxt = S_MEM;
                    OP_BEQ: begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SD) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (expired) begin
                    state_nxt   = S_TRAP;
                    timeout_set = 1'b1;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_a_sel    = ASEL_PC;
        alu_b_sel    = BSEL_RS2;
        alu_op       = ALU_ADD;
        aluout_we    = 1'b0;
        mdr_we       = 1'b0;
        reg_we       = 1'b0;
        mem_to_reg   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = ASEL_PC;
                alu_b_sel = BSEL_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_a_sel = ASEL_OLDPC;
                alu_b_sel = BSEL_IMM;
                aluout_we = 1'b1;
            end
            S_EXEC: begin
                alu_a_sel = ASEL_RS1;
                case (opcode)
                    OP_R: begin
                        alu_op    = ALU_FUNCT;
                        aluout_we = 1'b1;
                    end
                    OP_I: begin
                        alu_b_sel = BSEL_IMM;
                        alu_op    = ALU_FUNCT;
                        aluout_we = 1'b1;
                    end
                    OP_LD, OP_SD: begin
                        alu_b_sel = BSEL_IMM;
                        aluout_we = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_we  = alu_zero;
                        pc_src = alu_zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_SD);
                mdr_we       = mem_ready && (opcode == OP_LD);
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (opcode == OP_LD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (illegal_set) illegal <= 1'b1;
            if (timeout_set) timeout <= 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign cycle_cnt     = '0;
    assign instret_cnt   = '0;
`endif

endmodule
